// File: rtl/myproject_mac_pkg.sv
// myproject_mac_pkg: shared widths and the round/saturate helper
// used by the pipelined multiply-accumulate unit.
package myproject_mac_pkg;

    localparam int MIN_NUM_STAGE = 2;
    localparam int SAT_W = 128;

    typedef struct packed {
        logic             sat;
        logic [SAT_W-1:0] val;
    } sat_res_t;

    function automatic int acc_width_f(
        input int w0,
        input int w1,
        input int n
    );
        return w0 + w1 + $clog2(n) + 1;
    endfunction

    // Caller extends the accumulator to SAT_W bits, so the rounding
    // add can never overflow for any legal accumulator width.
    function automatic sat_res_t sat_round_f(
        input logic signed [SAT_W-1:0] a,
        input int                      frac,
        input int                      out_w,
        input logic                    sgn
    );
        logic signed [SAT_W-1:0] rnd;
        logic signed [SAT_W-1:0] r;
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        sat_res_t                res;
        rnd = '0;
        if (frac > 0) begin
            rnd = SAT_W'(1) <<< (frac - 1);
        end
        r = (a + rnd) >>> frac;
        if (sgn) begin
            hi = (SAT_W'(1) <<< (out_w - 1)) - 1;
            lo = -(SAT_W'(1) <<< (out_w - 1));
        end else begin
            hi = (SAT_W'(1) <<< out_w) - 1;
            lo = '0;
        end
        res.sat = 1'b0;
        res.val = r;
        if (r > hi) begin
            res.sat = 1'b1;
            res.val = hi;
        end else if (r < lo) begin
            res.sat = 1'b1;
            res.val = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/myproject_mac_mul_pipe.sv
// myproject_mac_mul_pipe: signedness-aware multiplier of depth
// NUM_STAGE carrying a valid bit alongside the product.
module myproject_mac_mul_pipe
    import myproject_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 24,
    parameter int DIN1_WIDTH = 18,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int NUM_STAGE  = 3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             ce_i,
    input  logic                             clear_i,
    input  logic                             valid_i,
    input  logic [DIN0_WIDTH-1:0]            din0_i,
    input  logic [DIN1_WIDTH-1:0]            din1_i,
    output logic                             valid_o,
    output logic [DIN0_WIDTH+DIN1_WIDTH-1:0] prod_o
);

    localparam int P = DIN0_WIDTH + DIN1_WIDTH;
    localparam int D = (NUM_STAGE < MIN_NUM_STAGE) ? MIN_NUM_STAGE : NUM_STAGE;

    logic [DIN0_WIDTH-1:0]   a_q;
    logic [DIN1_WIDTH-1:0]   b_q;
    logic signed [DIN0_WIDTH:0] a_x;
    logic signed [DIN1_WIDTH:0] b_x;
    logic signed [P-1:0]     a_e;
    logic signed [P-1:0]     b_e;
    logic signed [P-1:0]     mul;
    logic [P-1:0]            p_q [D-1];
    logic [D-1:0]            v_q;

    // One extra bit per operand makes a single signed multiply exact
    // for every signedness combination once truncated to P bits.
    always_comb begin
        a_x = {(SIGNED0 != 0) & a_q[DIN0_WIDTH-1], a_q};
        b_x = {(SIGNED1 != 0) & b_q[DIN1_WIDTH-1], b_q};
        a_e = P'(a_x);
        b_e = P'(b_x);
        mul = a_e * b_e;
    end

    always_ff @(posedge clk) begin
        if (ce_i) begin
            a_q    <= din0_i;
            b_q    <= din1_i;
            p_q[0] <= mul;
            for (int i = 1; i < D - 1; i++) begin
                p_q[i] <= p_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v_q <= '0;
        end else if (ce_i) begin
            if (clear_i) begin
                v_q <= D'(valid_i);
            end else begin
                v_q <= {v_q[D-2:0], valid_i};
            end
        end
    end

    assign valid_o = v_q[D-1];
    assign prod_o  = p_q[D-2];

endmodule

// File: rtl/myproject_mac_pipe.sv
// myproject_mac_pipe: pipelined MAC with grouped accumulation and a
// registered round-and-saturate output stage.
module myproject_mac_pipe
    import myproject_mac_pkg::*;
#(
    parameter int DIN0_WIDTH = 24,
    parameter int DIN1_WIDTH = 18,
    parameter int SIGNED0    = 0,
    parameter int SIGNED1    = 0,
    parameter int NUM_STAGE  = 3,
    parameter int ACC_LEN    = 9,
    parameter int ACC_WIDTH  = acc_width_f(DIN0_WIDTH, DIN1_WIDTH, ACC_LEN),
    parameter int FRAC_SHIFT = 0,
    parameter int OUT_WIDTH  = 37
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  in_valid,
    input  logic                  in_clear,
    input  logic [DIN0_WIDTH-1:0] din0,
    input  logic [DIN1_WIDTH-1:0] din1,
    output logic                  out_valid,
    output logic                  out_sat,
    output logic [OUT_WIDTH-1:0]  dout
);

    localparam int P   = DIN0_WIDTH + DIN1_WIDTH;
    localparam bit SGN = (SIGNED0 != 0) || (SIGNED1 != 0);
    localparam int CW  = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

    logic                    pv;
    logic [P-1:0]            prod;
    logic                    take;
    logic                    close_d;
    logic                    close_q;
    logic [ACC_WIDTH-1:0]    p_ext;
    logic [ACC_WIDTH-1:0]    acc_d;
    logic [ACC_WIDTH-1:0]    acc_q;
    logic [CW-1:0]           cnt_d;
    logic [CW-1:0]           cnt_q;
    logic signed [SAT_W-1:0] acc_x;
    sat_res_t                res;
    logic                    unused_hi;

    myproject_mac_mul_pipe #(
        .DIN0_WIDTH (DIN0_WIDTH),
        .DIN1_WIDTH (DIN1_WIDTH),
        .SIGNED0    (SIGNED0),
        .SIGNED1    (SIGNED1),
        .NUM_STAGE  (NUM_STAGE)
    ) u_mul (
        .clk     (clk),
        .reset   (reset),
        .ce_i    (ce),
        .clear_i (in_clear),
        .valid_i (in_valid),
        .din0_i  (din0),
        .din1_i  (din1),
        .valid_o (pv),
        .prod_o  (prod)
    );

    // A clear also kills the product landing here on the same edge.
    always_comb begin
        take    = pv & ~in_clear;
        close_d = take && (cnt_q == LAST);
        p_ext   = {{(ACC_WIDTH-P){SGN & prod[P-1]}}, prod};
        acc_d   = (cnt_q == '0) ? p_ext : acc_q + p_ext;
        cnt_d   = close_d ? '0 : cnt_q + CW'(1);
        acc_x   = {{(SAT_W-ACC_WIDTH){SGN & acc_q[ACC_WIDTH-1]}}, acc_q};
        res     = sat_round_f(acc_x, FRAC_SHIFT, OUT_WIDTH, SGN);
    end

    assign unused_hi = ^res.val[SAT_W-1:OUT_WIDTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q     <= '0;
            acc_q     <= '0;
            close_q   <= 1'b0;
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            dout      <= '0;
        end else if (ce) begin
            if (in_clear) begin
                cnt_q <= '0;
            end else if (take) begin
                cnt_q <= cnt_d;
                acc_q <= acc_d;
            end
            close_q   <= close_d;
            out_valid <= close_q;
            out_sat   <= close_q & res.sat;
            if (close_q) begin
                dout <= res.val[OUT_WIDTH-1:0];
            end
        end
    end

endmodule

// File: tb/tb_myproject_mac_pipe.sv
// tb_myproject_mac_pipe: three MAC configurations driven with directed
// and random traffic, checked against a transaction-level model.
module tb_myproject_mac_pipe;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic ce = 1'b1;
    always #5 clk = ~clk;

    logic        rv [3];
    logic        rc [3];
    logic [63:0] ra [3];
    logic [63:0] rb [3];
    logic        ov [3];
    logic        os [3];
    logic [36:0] d0;
    logic [7:0]  d1;
    logic [36:0] d2;

    int ns [3] = '{3, 2, 4};
    int al [3] = '{9, 2, 1};
    int fr [3] = '{0, 2, 0};
    int ow [3] = '{37, 8, 37};
    int w0 [3] = '{24, 8, 8};
    int w1 [3] = '{18, 8, 8};
    int s0 [3] = '{0, 1, 1};
    int s1 [3] = '{0, 1, 0};

    myproject_mac_pipe u_d0 (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(rv[0]), .in_clear(rc[0]),
        .din0(ra[0][23:0]), .din1(rb[0][17:0]),
        .out_valid(ov[0]), .out_sat(os[0]), .dout(d0)
    );

    myproject_mac_pipe #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .SIGNED0(1), .SIGNED1(1),
        .NUM_STAGE(2), .ACC_LEN(2), .FRAC_SHIFT(2), .OUT_WIDTH(8)
    ) u_d1 (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(rv[1]), .in_clear(rc[1]),
        .din0(ra[1][7:0]), .din1(rb[1][7:0]),
        .out_valid(ov[1]), .out_sat(os[1]), .dout(d1)
    );

    myproject_mac_pipe #(
        .DIN0_WIDTH(8), .DIN1_WIDTH(8), .SIGNED0(1), .SIGNED1(0),
        .NUM_STAGE(4), .ACC_LEN(1)
    ) u_d2 (
        .clk(clk), .reset(reset), .ce(ce),
        .in_valid(rv[2]), .in_clear(rc[2]),
        .din0(ra[2][7:0]), .din1(rb[2][7:0]),
        .out_valid(ov[2]), .out_sat(os[2]), .dout(d2)
    );

    int     total = 0;
    int     bad = 0;
    int     edge_n = 0;
    int     pe [3][$];
    longint pp [3][$];
    int     gn [3];
    longint gs [3];
    bit     sv [3];
    bit     ssat [3];
    longint sval [3];
    bit     eov [3];
    bit     esat [3];
    longint edo [3];
    longint lgv [3][$];
    bit     lgs [3][$];

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    function automatic longint opv(logic [63:0] raw, int w, int s);
        longint x;
        x = longint'(raw & ((64'd1 << w) - 64'd1));
        if (s != 0 && x[w-1]) x = x - (longint'(1) << w);
        return x;
    endfunction

    function automatic logic [63:0] obs(int k);
        case (k)
            0:       return 64'(d0);
            1:       return 64'(d1);
            default: return 64'(d2);
        endcase
    endfunction

    function automatic longint lg(int k, int i);
        if (i < lgv[k].size()) return lgv[k][i];
        return -1;
    endfunction

    function automatic longint lgsat(int k, int i);
        if (i < lgs[k].size()) return longint'(lgs[k][i]);
        return -1;
    endfunction

    task automatic close_grp(int k);
        longint r, hi, lo;
        bit sg;
        sg = (s0[k] | s1[k]) != 0;
        r = gs[k];
        if (fr[k] > 0) r = r + (longint'(1) << (fr[k] - 1));
        r = r >>> fr[k];
        hi = sg ? (longint'(1) << (ow[k] - 1)) - 1 : (longint'(1) << ow[k]) - 1;
        lo = sg ? -(longint'(1) << (ow[k] - 1)) : 0;
        ssat[k] = (r > hi) || (r < lo);
        sval[k] = (r > hi) ? hi : ((r < lo) ? lo : r);
        sval[k] = sval[k] & ((longint'(1) << ow[k]) - 1);
        sv[k] = 1'b1;
        gn[k] = 0;
        gs[k] = 0;
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            pe[k].delete();
            pp[k].delete();
            gn[k] = 0; gs[k] = 0; sv[k] = 0;
            eov[k] = 0; esat[k] = 0; edo[k] = 0;
        end
    endtask

    // Operand pair sampled on enabled edge e reaches the accumulator on
    // edge e+NUM_STAGE; a closed group shows at the output one edge later.
    task automatic model_step(int k);
        eov[k] = sv[k];
        if (sv[k]) begin
            edo[k] = sval[k];
            esat[k] = ssat[k];
        end else begin
            esat[k] = 1'b0;
        end
        sv[k] = 1'b0;
        if (rc[k]) begin
            pe[k].delete();
            pp[k].delete();
            gn[k] = 0;
            gs[k] = 0;
        end else if (pe[k].size() > 0 && pe[k][0] == edge_n - ns[k]) begin
            void'(pe[k].pop_front());
            gs[k] = gs[k] + pp[k].pop_front();
            gn[k]++;
            if (gn[k] == al[k]) close_grp(k);
        end
        if (rv[k]) begin
            pe[k].push_back(edge_n);
            pp[k].push_back(opv(ra[k], w0[k], s0[k]) * opv(rb[k], w1[k], s1[k]));
        end
    endtask

    task automatic cyc();
        bit en;
        @(posedge clk);
        en = ce && reset;
        if (!reset) begin
            model_reset();
        end else if (ce) begin
            edge_n++;
            for (int k = 0; k < 3; k++) model_step(k);
        end
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("ov%0d", k), 64'(ov[k]), 64'(eov[k]));
            chk($sformatf("sat%0d", k), 64'(os[k]), 64'(esat[k]));
            chk($sformatf("dout%0d", k), obs(k), edo[k]);
            if (en && ov[k]) begin
                lgv[k].push_back(longint'(obs(k)));
                lgs[k].push_back(os[k]);
            end
        end
    endtask

    task automatic put(int k, bit v, bit c, longint a, longint b);
        rv[k] = v; rc[k] = c; ra[k] = a; rb[k] = b;
    endtask

    task automatic idle();
        for (int k = 0; k < 3; k++) put(k, 0, 0, 0, 0);
    endtask

    task automatic async_rst();
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ov%0d", k), 64'(ov[k]), 64'd0);
            chk($sformatf("rst_sat%0d", k), 64'(os[k]), 64'd0);
            chk($sformatf("rst_dout%0d", k), obs(k), 64'd0);
        end
        cyc();
        reset = 1'b1;
    endtask

    initial begin
        int b0, b1, b2;
        bit done;
        idle();
        model_reset();
        repeat (2) cyc();
        reset = 1'b1;
        cyc();

        b0 = lgv[0].size();
        for (int i = 1; i <= 9; i++) begin put(0, 1, 0, i, i); cyc(); end
        for (int i = 0; i < 9; i++) begin
            put(0, 1, 0, $urandom_range(0, 500), $urandom_range(0, 500));
            cyc();
        end
        idle();
        repeat (8) cyc();
        chk("sum285", lg(0, b0), 285);
        chk("sum285_sat", lgsat(0, b0), 0);
        chk("two_groups", lgv[0].size() - b0, 2);

        b1 = lgv[1].size();
        put(1, 1, 0, 10, 10);   cyc();
        put(1, 1, 0, 14, 7);    cyc();
        put(1, 1, 0, 100, 5);   cyc(); cyc();
        put(1, 1, 0, -100, 5);  cyc(); cyc();
        idle();
        repeat (6) cyc();
        chk("rnd50", lg(1, b1), 50);
        chk("rnd50_sat", lgsat(1, b1), 0);
        chk("pos_clip", lg(1, b1 + 1), 127);
        chk("pos_clip_sat", lgsat(1, b1 + 1), 1);
        chk("neg_clip", lg(1, b1 + 2), 'h80);
        chk("neg_clip_sat", lgsat(1, b1 + 2), 1);

        b2 = lgv[2].size();
        put(2, 1, 0, 'h80, 'hFF); cyc();
        idle();
        repeat (7) cyc();
        chk("mixed_sign", lg(2, b2), (longint'(1) << 37) - 32640);

        b0 = lgv[0].size();
        for (int i = 0; i < 4; i++) begin
            put(0, 1, 0, $urandom_range(1, 50), $urandom_range(1, 50));
            cyc();
        end
        put(0, 1, 1, 2, 3); cyc();
        for (int i = 0; i < 8; i++) begin put(0, 1, 0, 1, 1); cyc(); end
        idle();
        repeat (8) cyc();
        chk("clear_sum", lg(0, b0), 14);
        chk("clear_count", lgv[0].size() - b0, 1);

        b0 = lgv[0].size();
        for (int i = 1; i <= 9; i++) begin
            put(0, 1, 0, i, i);
            cyc();
            if (i == 4) begin
                ce = 1'b0;
                repeat (3) cyc();
                ce = 1'b1;
            end
        end
        idle();
        done = 1'b0;
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (ov[0] && !done) begin
                done = 1'b1;
                ce = 1'b0;
                repeat (3) begin
                    cyc();
                    chk("stall_ov", 64'(ov[0]), 64'd1);
                end
                ce = 1'b1;
            end
        end
        chk("stall_seen", 64'(done), 64'd1);
        chk("stall_sum", lg(0, b0), 285);

        for (int i = 0; i < 5; i++) begin put(0, 1, 0, 7, 7); cyc(); end
        async_rst();
        b0 = lgv[0].size();
        for (int i = 1; i <= 9; i++) begin put(0, 1, 0, i, i); cyc(); end
        idle();
        repeat (8) cyc();
        chk("post_rst_sum", lg(0, b0), 285);
        chk("post_rst_count", lgv[0].size() - b0, 1);

        for (int n = 0; n < 600; n++) begin
            ce = ($urandom_range(0, 9) != 0);
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(0, 1) == 1)
                    put(k, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                        {$urandom, $urandom}, {$urandom, $urandom});
                else
                    put(k, $urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0,
                        $urandom_range(0, 1000), $urandom_range(0, 1000));
            end
            cyc();
            if (n == 300) async_rst();
        end
        ce = 1'b1;
        idle();
        repeat (10) cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
